// File: rtl/tape_reader_dev_if.sv
// rtl/tape_reader_dev_if.sv - host symbol stream and I/O-unit handshake bundle for the tape reader
interface tape_reader_dev_if;
  logic       host_val;
  logic       host_rdy;
  logic [4:0] host_data;
  logic       input_rdy_from_io;
  logic       input_val_to_io;
  logic [4:0] input_data_to_io;

  modport master (
    output host_val, host_data, input_rdy_from_io,
    input  host_rdy, input_val_to_io, input_data_to_io
  );

  modport slave (
    input  host_val, host_data, input_rdy_from_io,
    output host_rdy, input_val_to_io, input_data_to_io
  );
endinterface

// File: rtl/tape_reader_dev.sv
// rtl/tape_reader_dev.sv - photo-tape reader model: symbol FIFO feeding the I/O unit via a 4-phase handshake
// SENT_INIT only moves the power-on value of the delivered-symbol counter.
module tape_reader_dev #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          GAP_CYCLES = 8,
  parameter logic [15:0] SENT_INIT  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  tape_reader_dev_if.slave      bus,
  input  logic                  flush_from_pnl,
  output logic [DEPTH_LOG2:0]   fifo_count_to_pnl,
  output logic                  end_seen_to_pnl,
  output logic [15:0]           sent_count_to_pnl
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL   = DEPTH[DEPTH_LOG2:0];
  localparam logic [15:0]       GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_OFFER = 4'b0010,
    S_VAL   = 4'b0100,
    S_GAP   = 4'b1000
  } state_t;

  state_t                state, state_nx;
  logic [4:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [4:0]            data_q;
  logic                  val_q;
  logic                  end_seen_q;
  logic [15:0]           sent_q;
  logic [15:0]           gap_cnt;
  logic                  flush_pend;

  logic fifo_open, push, deliver, clear, load, flush_req, data_is_end;

  assign fifo_open   = (count < FULL);
  assign push        = bus.host_val && fifo_open && !flush_from_pnl;
  assign flush_req   = flush_from_pnl || flush_pend;
  assign data_is_end = ((data_q & 5'b10111) == 5'b00111);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // A flush seen during VAL never aborts the handshake; it takes effect when rdy drops.
  always_comb begin
    state_nx = state;
    deliver  = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_from_pnl) begin
          clear = 1'b1;
        end else if (count != '0) begin
          state_nx = S_OFFER;
          load     = 1'b1;
        end
      end
      S_OFFER: begin
        if (flush_from_pnl) begin
          clear    = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.input_rdy_from_io) begin
          state_nx = S_VAL;
        end
      end
      S_VAL: begin
        if (!bus.input_rdy_from_io) begin
          deliver = 1'b1;
          if (flush_req) begin
            clear    = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (flush_from_pnl) begin
          clear    = 1'b1;
          state_nx = S_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.host_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (deliver) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, deliver};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      val_q      <= 1'b0;
      data_q     <= 5'd0;
      end_seen_q <= 1'b0;
      sent_q     <= SENT_INIT;
      gap_cnt    <= 16'd0;
      flush_pend <= 1'b0;
    end else begin
      val_q      <= (state_nx == S_VAL);
      gap_cnt    <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
      flush_pend <= (state == S_VAL) && !deliver && flush_req;
      if (load)    data_q <= mem[rd_ptr];
      if (deliver) sent_q <= sent_q + 16'd1;
      // Clearing has priority so a flushed end symbol leaves end_seen low.
      if (clear)                       end_seen_q <= 1'b0;
      else if (deliver && data_is_end) end_seen_q <= 1'b1;
    end
  end

  assign bus.host_rdy         = fifo_open;
  assign bus.input_val_to_io  = val_q;
  assign bus.input_data_to_io = data_q;
  assign fifo_count_to_pnl    = count;
  assign end_seen_to_pnl      = end_seen_q;
  assign sent_count_to_pnl    = sent_q;

endmodule

// File: tb/tb_tape_reader_dev.sv
// tb/tb_tape_reader_dev.sv - directed and randomized bench for tape_reader_dev against a queue model
module tb_tape_reader_dev;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [4:0]  fifo_count;
  logic        end_seen;
  logic [15:0] sent_count;
  logic        w_flush;
  logic [4:0]  w_fifo_count;
  logic        w_end_seen;
  logic [15:0] w_sent_count;

  always #5 clk = ~clk;

  tape_reader_dev_if bus ();
  tape_reader_dev_if w_bus ();

  tape_reader_dev #(.DEPTH_LOG2(4), .GAP_CYCLES(8)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .bus               (bus),
    .flush_from_pnl    (flush),
    .fifo_count_to_pnl (fifo_count),
    .end_seen_to_pnl   (end_seen),
    .sent_count_to_pnl (sent_count)
  );

  tape_reader_dev #(.DEPTH_LOG2(4), .GAP_CYCLES(0), .SENT_INIT(16'hFFFF)) u_wrap (
    .clk               (clk),
    .resetn            (resetn),
    .bus               (w_bus),
    .flush_from_pnl    (w_flush),
    .fifo_count_to_pnl (w_fifo_count),
    .end_seen_to_pnl   (w_end_seen),
    .sent_count_to_pnl (w_sent_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] mq[$];
  int         m_sent = 0;
  bit         m_end  = 1'b0;

  function automatic bit is_end_code(logic [4:0] d);
    return (d & 5'b10111) == 5'b00111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [4:0] d);
    chk("host_rdy", bus.host_rdy, mq.size() < 16);
    bus.host_val  = 1'b1;
    bus.host_data = d;
    step();
    bus.host_val  = 1'b0;
    if (mq.size() < 16) mq.push_back(d);
  endtask

  task automatic wait_val(input logic exp, input string tag, output int t);
    int n;
    n = 0;
    while (n < 64 && bus.input_val_to_io !== exp) begin
      step();
      n++;
    end
    t = cyc;
    chk(tag, bus.input_val_to_io, exp);
  endtask

  task automatic handshake(output int t_rdy, output int t_rise, output int t_fall);
    logic [4:0] exp_d;
    chk("val_low_before_rdy", bus.input_val_to_io, 1'b0);
    bus.input_rdy_from_io = 1'b1;
    t_rdy = cyc;
    wait_val(1'b1, "val_rise", t_rise);
    exp_d = (mq.size() > 0) ? mq[0] : 5'h1F;
    chk("data", bus.input_data_to_io, exp_d);
    bus.input_rdy_from_io = 1'b0;
    wait_val(1'b0, "val_fall", t_fall);
    chk("data_held", bus.input_data_to_io, exp_d);
    if (mq.size() > 0) void'(mq.pop_front());
    m_sent++;
    m_end = m_end | is_end_code(exp_d);
    chk("sent_count", sent_count, m_sent & 16'hFFFF);
    chk("end_seen", end_seen, m_end);
    chk("fifo_count", fifo_count, mq.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int t_rdy, t_r1, t_f1, t_r2, t_f2, t, vh, n;
    logic [4:0] d;

    resetn = 1'b0;
    flush  = 1'b0;
    w_flush = 1'b0;
    bus.host_val = 1'b0;
    bus.host_data = 5'd0;
    bus.input_rdy_from_io = 1'b0;
    w_bus.host_val = 1'b0;
    w_bus.host_data = 5'd0;
    w_bus.input_rdy_from_io = 1'b0;
    idle(3);
    chk("rst_val", bus.input_val_to_io, 1'b0);
    chk("rst_data", bus.input_data_to_io, 5'd0);
    chk("rst_fifo", fifo_count, 5'd0);
    chk("rst_sent", sent_count, 16'd0);
    chk("rst_end", end_seen, 1'b0);
    chk("w_preset", w_sent_count, 16'hFFFF);
    resetn = 1'b1;
    step();
    chk("rst_host_rdy", bus.host_rdy, 1'b1);

    // Three directed symbols, rdy pulsed with random spacing
    push(5'b10000);
    push(5'b10101);
    push(5'b00111);
    chk("A_fifo", fifo_count, 5'd3);
    for (int k = 0; k < 3; k++) begin
      idle($urandom_range(0, 5));
      handshake(t_rdy, t_r1, t_f1);
    end
    chk("A_sent", sent_count, 16'd3);
    chk("A_end", end_seen, 1'b1);
    chk("A_fifo_empty", fifo_count, 5'd0);

    // Reader speed: latency from rdy and gap between symbols
    idle(12);
    push(5'($urandom));
    push(5'($urandom));
    idle(4);
    handshake(t_rdy, t_r1, t_f1);
    chk("B_rise_latency", t_r1 - t_rdy, 1);
    handshake(t_rdy, t_r2, t_f2);
    chk("B_gap_ok", ((t_r2 - t_f1) >= 8) && ((t_r2 - t_f1) <= 12), 1'b1);

    // Fill past full with the I/O unit not ready
    idle(12);
    for (int k = 0; k < 17; k++) begin
      chk("C_count", fifo_count, mq.size());
      push(5'($urandom));
    end
    chk("C_host_rdy_full", bus.host_rdy, 1'b0);
    chk("C_fifo_full", fifo_count, 5'd16);
    for (int k = 0; k < 16; k++) handshake(t_rdy, t_r1, t_f1);
    chk("C_drained", fifo_count, 5'd0);

    // Flush while a symbol is in VAL
    idle(12);
    push(5'b00111);
    for (int k = 0; k < 4; k++) push(5'($urandom));
    idle(4);
    bus.input_rdy_from_io = 1'b1;
    wait_val(1'b1, "D_val_rise", t);
    chk("D_data", bus.input_data_to_io, mq[0]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("D_val_held", bus.input_val_to_io, 1'b1);
    bus.input_rdy_from_io = 1'b0;
    wait_val(1'b0, "D_val_fall", t);
    m_sent++;
    mq.delete();
    m_end = 1'b0;
    step();
    chk("D_fifo", fifo_count, 5'd0);
    chk("D_end", end_seen, 1'b0);
    chk("D_sent", sent_count, m_sent);
    bus.input_rdy_from_io = 1'b1;
    vh = 0;
    repeat (30) begin
      step();
      if (bus.input_val_to_io) vh++;
    end
    chk("D_no_val", vh, 0);
    bus.input_rdy_from_io = 1'b0;

    // Flush in OFFER coinciding with a host push
    push(5'($urandom));
    push(5'($urandom));
    idle(2);
    bus.host_val  = 1'b1;
    bus.host_data = 5'($urandom);
    flush = 1'b1;
    step();
    bus.host_val = 1'b0;
    flush = 1'b0;
    mq.delete();
    chk("E_fifo", fifo_count, 5'd0);
    chk("E_val", bus.input_val_to_io, 1'b0);
    push(5'($urandom));
    idle(3);
    handshake(t_rdy, t_r1, t_f1);

    // Reset while val is high
    idle(12);
    push(5'($urandom));
    idle(4);
    bus.input_rdy_from_io = 1'b1;
    wait_val(1'b1, "F_val_rise", t);
    #2;
    resetn = 1'b0;
    #1;
    chk("F_val", bus.input_val_to_io, 1'b0);
    chk("F_fifo", fifo_count, 5'd0);
    chk("F_sent", sent_count, 16'd0);
    bus.input_rdy_from_io = 1'b0;
    mq.delete();
    m_sent = 0;
    m_end = 1'b0;
    idle(2);
    resetn = 1'b1;
    step();
    chk("F_host_rdy", bus.host_rdy, 1'b1);

    // Delivered-symbol counter wrap on the preset instance
    for (int k = 0; k < 2; k++) begin
      d = 5'($urandom);
      w_bus.host_val  = 1'b1;
      w_bus.host_data = d;
      step();
      w_bus.host_val = 1'b0;
      w_bus.input_rdy_from_io = 1'b1;
      n = 0;
      while (n < 64 && w_bus.input_val_to_io !== 1'b1) begin step(); n++; end
      chk("G_val_rise", w_bus.input_val_to_io, 1'b1);
      chk("G_data", w_bus.input_data_to_io, d);
      w_bus.input_rdy_from_io = 1'b0;
      n = 0;
      while (n < 64 && w_bus.input_val_to_io !== 1'b0) begin step(); n++; end
      chk("G_val_fall", w_bus.input_val_to_io, 1'b0);
      chk("G_sent", w_sent_count, (k == 0) ? 16'h0000 : 16'h0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
